// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencing controller for the dOrv32 core.
//
// Merges redirect requests (EX-stage jump, trap) and stall sources
// (load-use hazard, multi-cycle mul/div, LSU wait) into per-stage
// stall/flush controls. A accepted redirect is issued as a registered
// one-cycle PC load strobe, followed by a FLUSH_CYCLES-long window in
// which ID is bubbled while fetch refills.
//
// Parameters:
//   FLUSH_CYCLES  cycles ID is bubbled after a redirect (>= 1)
//   RESET_VEC     fetch address issued on boot
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   jflag_in/jaddr_in  EX-stage taken jump/branch and its target
//   trap_req/trap_vec  trap request (level, held until trap_ack) and target
//   lu_hazard          load-use hazard detected in ID
//   md_busy            mul/div occupying EX
//   lsu_ready          LSU idle/accepting (0 = outstanding access)
//   trap_ack           trap accepted this cycle (combinational)
//   redirect_valid     PC load strobe (registered, single-cycle pulse)
//   redirect_addr      PC load value (registered, holds last value)
//   stall_if/id/ex     hold stage register
//   flush_id/ex        insert bubble into stage
//   hold_out           core hold: in reset, fetch stalled, or not in RUN
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jflag_in,
  input  logic [31:0] jaddr_in,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        lu_hazard,
  input  logic        md_busy,
  input  logic        lsu_ready,
  output logic        trap_ack,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        hold_out
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_addr_q, redirect_addr_d;

  // Redirect request raised by any state; the common tail of the
  // next-state logic turns it into the strobe, target and flush window.
  logic            load_redir;
  logic [31:0]     load_addr;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = redirect_addr_q;
    load_redir       = 1'b0;
    load_addr        = redirect_addr_q;
    trap_ack         = 1'b0;
    stall_if         = 1'b0;
    stall_id         = 1'b0;
    stall_ex         = 1'b0;
    flush_id         = 1'b0;
    flush_ex         = 1'b0;

    unique case (state_q)
      BOOT: begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        stall_ex   = 1'b1;
        flush_id   = 1'b1;
        flush_ex   = 1'b1;
        load_redir = 1'b1;
        load_addr  = RESET_VEC;
      end

      RUN: begin
        if (trap_req && lsu_ready) begin
          // Trap beats a simultaneous jump; the instruction in EX is killed.
          trap_ack   = 1'b1;
          flush_id   = 1'b1;
          flush_ex   = 1'b1;
          stall_if   = 1'b1;
          load_redir = 1'b1;
          load_addr  = trap_vec;
        end else if (trap_req) begin
          // Outstanding memory access must complete before the trap is taken.
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = DRAIN;
        end else if (jflag_in && !md_busy && lsu_ready) begin
          // The jumping instruction itself proceeds, so EX is not flushed.
          flush_id   = 1'b1;
          stall_if   = 1'b1;
          load_redir = 1'b1;
          load_addr  = jaddr_in;
        end else if (md_busy || !lsu_ready) begin
          // Full EX stall; a pending jump will be re-presented once EX frees.
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end else if (lu_hazard) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end

      DRAIN: begin
        if (!trap_req) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = RUN;
        end else if (lsu_ready) begin
          trap_ack   = 1'b1;
          flush_id   = 1'b1;
          flush_ex   = 1'b1;
          stall_if   = 1'b1;
          load_redir = 1'b1;
          load_addr  = trap_vec;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end
      end

      FLUSH: begin
        // Everything arriving here is wrong-path; jumps are ignored and
        // traps wait until RUN.
        flush_id = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    if (load_redir) begin
      redirect_valid_d = 1'b1;
      redirect_addr_d  = load_addr;
      cnt_d            = CW'(FLUSH_CYCLES);
      state_d          = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= BOOT;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= RESET_VEC;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign hold_out       = !rst || stall_if || (state_q != RUN);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vectors with hand-computed control
// patterns checked in the cycle they are driven, and a redirect scoreboard
// (expected PC loads queued at acceptance, popped by a monitor whenever
// redirect_valid is seen).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jflag_in;
  logic [31:0] jaddr_in;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        lu_hazard;
  logic        md_busy;
  logic        lsu_ready;
  logic        trap_ack;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, hold_out;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // {trap_ack, stall_if, stall_id, stall_ex, flush_id, flush_ex, hold_out}
  localparam logic [6:0] C_BOOT  = 7'b0111111;
  localparam logic [6:0] C_FLUSH = 7'b0000101;
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_JUMP  = 7'b0100101;
  localparam logic [6:0] C_TRAP  = 7'b1100111;
  localparam logic [6:0] C_STALL = 7'b0111001;
  localparam logic [6:0] C_LU    = 7'b0110011;

  pipe_ctrl #(.FLUSH_CYCLES(2), .RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .jflag_in(jflag_in), .jaddr_in(jaddr_in),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .lu_hazard(lu_hazard), .md_busy(md_busy), .lsu_ready(lsu_ready),
    .trap_ack(trap_ack),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .hold_out(hold_out)
  );

  always #5 clk = ~clk;

  // Redirect monitor: every PC load strobe must match the oldest queued target.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL redirect_unexpected: got addr=%08h, required no redirect", redirect_addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (redirect_addr !== e) begin
          n_err++;
          $display("FAIL redirect_addr: got %08h, required %08h", redirect_addr, e);
        end else begin
          $display("redirect addr=%08h ok", redirect_addr);
        end
      end
    end
  end

  // One stimulus cycle: drive inputs after the falling edge, then check
  // the combinational controls before the next rising edge.
  task automatic cyc(input string name, input logic r, input logic jf, input logic [31:0] ja,
                     input logic tr, input logic [31:0] tv, input logic lu, input logic md,
                     input logic lr, input logic [6:0] exp_ctrl);
    logic [6:0] got;
    @(negedge clk);
    rst = r; jflag_in = jf; jaddr_in = ja; trap_req = tr; trap_vec = tv;
    lu_hazard = lu; md_busy = md; lsu_ready = lr;
    #1;
    got = {trap_ack, stall_if, stall_id, stall_ex, flush_id, flush_ex, hold_out};
    n_vec++;
    if (got !== exp_ctrl) begin
      n_err++;
      $display("FAIL %s: got ctrl=%b, required %b", name, got, exp_ctrl);
    end else begin
      $display("%s ctrl=%b ok", name, got);
    end
  endtask

  task automatic check_reg(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end else begin
      $display("%s = %h ok", name, got);
    end
  endtask

  initial begin
    rst = 1'b0; jflag_in = 1'b0; jaddr_in = '0; trap_req = 1'b0; trap_vec = '0;
    lu_hazard = 1'b0; md_busy = 1'b0; lsu_ready = 1'b1;

    // Reset state
    cyc("reset0", 0, 0, 0, 0, 0, 0, 0, 1, C_BOOT);
    check_reg("reset_redir", {redirect_valid, redirect_addr}, {1'b0, 32'h0});
    cyc("reset1", 0, 0, 0, 0, 0, 0, 0, 1, C_BOOT);

    // Boot: release reset, redirect to RESET_VEC, two flush cycles, RUN
    cyc("boot", 1, 0, 0, 0, 0, 0, 0, 1, C_BOOT);
    exp_q.push_back(32'h0000_0000);
    cyc("boot_fl1", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("boot_fl2", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("boot_run", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Jump; a second jump pulse inside FLUSH is ignored
    cyc("jump", 1, 1, 32'h100, 0, 0, 0, 0, 1, C_JUMP);
    exp_q.push_back(32'h0000_0100);
    cyc("jump_fl1", 1, 1, 32'h200, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("jump_fl2", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("jump_run", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Trap with LSU drain for 3 cycles
    cyc("trap_wait0", 1, 0, 0, 1, 32'h80, 0, 0, 0, C_STALL);
    cyc("drain1", 1, 0, 0, 1, 32'h80, 0, 0, 0, C_STALL);
    cyc("drain2", 1, 0, 0, 1, 32'h80, 0, 0, 0, C_STALL);
    cyc("drain_ack", 1, 0, 0, 1, 32'h80, 0, 0, 1, C_TRAP);
    exp_q.push_back(32'h0000_0080);
    cyc("trap_fl1", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("trap_fl2", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("trap_run", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Trap and jump in the same cycle: only trap_vec is loaded
    cyc("trap_jump", 1, 1, 32'h300, 1, 32'h40, 0, 0, 1, C_TRAP);
    exp_q.push_back(32'h0000_0040);
    cyc("tj_fl1", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("tj_fl2", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("tj_run", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Trap withdrawn during DRAIN: back to RUN, no ack, no redirect
    cyc("drop_t0", 1, 0, 0, 1, 32'h44, 0, 0, 0, C_STALL);
    cyc("drop_t1", 1, 0, 0, 0, 32'h44, 0, 0, 0, C_STALL);
    cyc("drop_run", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Load-use and mul/div stalls
    cyc("lu_only", 1, 0, 0, 0, 0, 1, 0, 1, C_LU);
    cyc("lu_md", 1, 0, 0, 0, 0, 1, 1, 1, C_STALL);
    cyc("md_jump", 1, 1, 32'h400, 0, 0, 0, 1, 1, C_STALL);
    cyc("md_after", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Reset in the middle of FLUSH
    cyc("jump2", 1, 1, 32'h500, 0, 0, 0, 0, 1, C_JUMP);
    exp_q.push_back(32'h0000_0500);
    cyc("j2_fl1", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("mid_rst", 0, 0, 0, 0, 0, 0, 0, 1, C_BOOT);
    check_reg("mid_rst_redir", {redirect_valid, redirect_addr}, {1'b0, 32'h0});
    cyc("reboot", 1, 0, 0, 0, 0, 0, 0, 1, C_BOOT);
    exp_q.push_back(32'h0000_0000);
    cyc("reboot_fl1", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("reboot_fl2", 1, 0, 0, 0, 0, 0, 0, 1, C_FLUSH);
    cyc("reboot_run", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);
    cyc("idle_end", 1, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Every queued redirect must have been observed
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL redirect_missing: got %0d outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the dOrv32 core. It merges redirect requests (EX-stage jump, trap) and stall sources (load-use hazard, multi-cycle mul/div, LSU wait) into per-stage stall/flush controls. It issues a registered one-cycle PC redirect and enforces a post-redirect flush window. It sits between the EX/LSU/CSR units and the IF/ID/EX pipeline registers, and owns the core's hold signal.

## Interface
- FLUSH_CYCLES, 2: cycles ID is bubbled after a redirect while fetch refills; legal range ≥1.
- RESET_VEC, 32'h0000_0000: fetch address issued on boot.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- jflag_in  in  1  EX-stage taken jump/branch.
- jaddr_in  in  32  jump target, valid with jflag_in.
- trap_req  in  1  trap/interrupt request; level, held until trap_ack.
- trap_vec  in  32  trap target, valid with trap_req.
- lu_hazard  in  1  load-use hazard detected in ID.
- md_busy  in  1  mul/div occupying EX.
- lsu_ready  in  1  LSU idle/accepting (0 = outstanding access).
- trap_ack  out  1  trap accepted (combinational, 1-cycle).
- redirect_valid  out  1  PC load strobe (registered).
- redirect_addr  out  32  PC load value (registered).
- stall_if, stall_id, stall_ex  out  1 each  hold stage register.
- flush_id, flush_ex  out  1 each  insert bubble into stage.
- hold_out  out  1  = !rst | stall_if | (state != RUN).

## Operation
- States: BOOT, RUN, DRAIN, FLUSH. Counter cnt width $clog2(FLUSH_CYCLES+1).
- BOOT (reset state): all stalls=1, flush_id=flush_ex=1. Next posedge: redirect_valid<=1, redirect_addr<=RESET_VEC, cnt<=FLUSH_CYCLES, go FLUSH.
- RUN, priority trap > jump > EX stall > load-use:
  - trap_req & lsu_ready: accept. trap_ack=1, flush_id=flush_ex=1, stall_if=1. Register redirect to trap_vec, load cnt, go FLUSH.
  - trap_req & !lsu_ready: go DRAIN. No ack.
  - jflag_in & !md_busy & lsu_ready: flush_id=1, stall_if=1, flush_ex=0. Register redirect to jaddr_in, load cnt, go FLUSH.
  - md_busy | !lsu_ready: stall_if=stall_id=stall_ex=1, no flush. jflag_in ignored.
  - lu_hazard: stall_if=stall_id=1, flush_ex=1.
  - Otherwise: all controls 0.
- DRAIN: stall_if=stall_id=stall_ex=1. jflag_in ignored.
  - When lsu_ready=1, accept the trap exactly as in RUN (same cycle).
  - If trap_req drops, return to RUN with no ack.
- FLUSH: flush_id=1, stall_* =0. Decrement cnt each cycle; on cnt==1 go RUN. jflag_in ignored (wrong path). trap_req not accepted, deferred to RUN.
- redirect_valid is a single-cycle pulse. redirect_addr holds its last value otherwise.
- Any rst low, including mid-FLUSH/DRAIN: immediately BOOT, cnt=0, redirect_valid=0, redirect_addr=RESET_VEC.

## Timing
- Reset values: redirect_valid=0, redirect_addr=RESET_VEC, trap_ack=0, stall_*=1, flush_id=flush_ex=1, hold_out=1.
- Redirect accepted in cycle T:
  - T+1: redirect_valid=1 with target.
  - T+1..T+FLUSH_CYCLES: state FLUSH.
  - T+FLUSH_CYCLES+1: RUN, new requests honoured.
- First fetch after rst rises: redirect at first posedge + 1 cycle, RUN after FLUSH_CYCLES more.
- Stall/flush/trap_ack are combinational from state and inputs; no added latency.
- Simultaneous trap_req & jflag_in in RUN: trap wins, jump dropped.
- Simultaneous lu_hazard & md_busy: full EX stall, no flush_ex.

## Test plan
- Boot: release rst. Cycle 1: redirect_valid=1, redirect_addr=0. Cycles 1–2: flush_id=1. Cycle 3: RUN, hold_out=0.
- Jump: RUN, jflag_in=1, jaddr_in=0x100. Same cycle: flush_id=1, flush_ex=0. Next cycle: redirect to 0x100. Jump pulse in FLUSH ignored; RUN after 2 cycles.
- Trap with drain: trap_req=1, trap_vec=0x80, lsu_ready=0 for 3 cycles. Expect DRAIN with all stalls and no ack. When lsu_ready=1: trap_ack=1, flush_id=flush_ex=1. Next cycle: redirect to 0x80.
- Trap + jump in the same cycle: only trap_vec is redirected; jaddr never appears.
- Load-use vs md_busy:
  - lu_hazard alone: stall_if=stall_id=flush_ex=1, stall_ex=0.
  - md_busy alone: all stalls=1, and jflag_in=1 produces no redirect.
- Reset mid-FLUSH: rst low for 1 cycle during FLUSH. Expect an immediate BOOT value on all outputs, then a fresh boot redirect to RESET_VEC.
